// File: rtl/throw_xpos.sv
// throw_xpos: horizontal trajectory and throw-termination stage.
// Launches a projectile on a throw request and steps its X position once per
// physics tick. It watches the Y position from the vertical generator to
// detect a target hit, landing or screen exit, and holds end_throw until the
// vertical generator has brought Y back to the ground line.
// Optional feature: define THROW_WIND_EN to add a signed 4-bit 'wind' input.
// Wind is added to the launch speed and the sum is clamped to 1..31.
module throw_xpos #(
    parameter int X_START_LEFT  = 100,
    parameter int X_START_RIGHT = 900,
    parameter int SCREEN_W      = 1024,
    parameter int GROUND_Y      = 768,
    parameter int TICK_DIV      = 100000,
    parameter int TARGET_W      = 64,
    parameter int TARGET_H      = 64
) (
    input  logic              clk60MHz,
    input  logic              rst,
    input  logic              in_throw_flag,
    input  logic              throw_flag,
    input  logic [4:0]        power,
`ifdef THROW_WIND_EN
    input  logic signed [3:0] wind,
`endif
    input  logic [11:0]       ypos_prebuff,
    input  logic [11:0]       target_xpos,
    input  logic [11:0]       target_ypos,
    output logic [11:0]       xpos_prebuff,
    output logic              end_throw,
    output logic              hit,
    output logic              busy
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic             dir_left;
    logic [4:0]       speed;

    // Launch speed: a power of zero would never move, so it counts as 1.
    logic [4:0] base_speed;
    logic [4:0] launch_speed;
    assign base_speed = (power == 5'd0) ? 5'd1 : power;

`ifdef THROW_WIND_EN
    // Wind is added to the launch speed. The result is clamped so the
    // projectile always moves and never exceeds the 5-bit speed range.
    logic signed [6:0] wind_sum;
    assign wind_sum = $signed({2'b00, base_speed}) + $signed({{3{wind[3]}}, wind});
    assign launch_speed = (wind_sum < 7'sd1)  ? 5'd1  :
                          (wind_sum > 7'sd31) ? 5'd31 : wind_sum[4:0];
`else
    assign launch_speed = base_speed;
`endif

    // All comparisons use 13 bits, so target edges near 4095 cannot wrap.
    logic [12:0] x13;
    logic [12:0] y13;
    logic [12:0] tx13;
    logic [12:0] ty13;
    logic [12:0] spd13;
    logic [12:0] x_right;
    logic [11:0] x_left;
    logic        target_hit;
    logic        grounded;
    logic        tick;
    logic        exit_right;
    logic        exit_left;

    assign x13     = {1'b0, xpos_prebuff};
    assign y13     = {1'b0, ypos_prebuff};
    assign tx13    = {1'b0, target_xpos};
    assign ty13    = {1'b0, target_ypos};
    assign spd13   = {8'd0, speed};
    assign x_right = x13 + spd13;
    assign x_left  = xpos_prebuff - {7'd0, speed};

    assign target_hit = (x13 >= tx13) && (x13 < tx13 + 13'(TARGET_W)) &&
                        (y13 >= ty13) && (y13 < ty13 + 13'(TARGET_H));
    assign grounded   = ypos_prebuff > 12'(GROUND_Y);
    assign tick       = (tick_cnt == TICK_LAST);
    assign exit_right = x_right >= 13'(SCREEN_W);
    assign exit_left  = x13 < spd13;

    // Throw state machine. All outputs are registered here. During flight,
    // the priority of the termination checks is hit, then ground, then exit.
    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            xpos_prebuff <= 12'(X_START_LEFT);
            end_throw    <= 1'b0;
            hit          <= 1'b0;
            busy         <= 1'b0;
            tick_cnt     <= '0;
            dir_left     <= 1'b0;
            speed        <= 5'd1;
        end else begin
            hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_throw_flag || throw_flag) begin
                        dir_left     <= !in_throw_flag;
                        xpos_prebuff <= in_throw_flag ? 12'(X_START_LEFT) : 12'(X_START_RIGHT);
                        speed        <= launch_speed;
                        tick_cnt     <= '0;
                        busy         <= 1'b1;
                        state        <= FLY;
                    end
                end
                FLY: begin
                    tick_cnt <= tick ? '0 : tick_cnt + CNT_ONE;
                    if (target_hit) begin
                        hit       <= 1'b1;
                        end_throw <= 1'b1;
                        state     <= DONE;
                    end else if (grounded) begin
                        end_throw <= 1'b1;
                        state     <= DONE;
                    end else if (tick) begin
                        if (!dir_left) begin
                            if (exit_right) begin
                                xpos_prebuff <= 12'(SCREEN_W - 1);
                                end_throw    <= 1'b1;
                                state        <= DONE;
                            end else begin
                                xpos_prebuff <= x_right[11:0];
                            end
                        end else begin
                            if (exit_left) begin
                                xpos_prebuff <= 12'd0;
                                end_throw    <= 1'b1;
                                state        <= DONE;
                            end else begin
                                xpos_prebuff <= x_left;
                            end
                        end
                    end
                end
                DONE: begin
                    if (ypos_prebuff == 12'(GROUND_Y)) begin
                        end_throw <= 1'b0;
                        busy      <= 1'b0;
                        tick_cnt  <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    end_throw <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_throw_xpos.sv
// tb_throw_xpos: self-checking bench for throw_xpos with TICK_DIV=4.
// The bench runs a table of throws with hand-derived outcomes, a few
// sequences for reset and for flag toggling, and randomized throws checked
// cycle by cycle against an arithmetic trajectory model.
module tb_throw_xpos;

    localparam int TICK     = 4;
    localparam int XL       = 100;
    localparam int XR       = 900;
    localparam int SCR_W    = 1024;
    localparam int GND      = 768;
    localparam int TGT      = 64;
    localparam int MAX_WAIT = 6000;

    logic              clk60MHz;
    logic              rst;
    logic              in_throw_flag;
    logic              throw_flag;
    logic [4:0]        power;
`ifdef THROW_WIND_EN
    logic signed [3:0] wind;
`endif
    logic [11:0]       ypos_prebuff;
    logic [11:0]       target_xpos;
    logic [11:0]       target_ypos;
    logic [11:0]       xpos_prebuff;
    logic              end_throw;
    logic              hit;
    logic              busy;

    int checks = 0;
    int errors = 0;

    throw_xpos #(
        .X_START_LEFT (XL),
        .X_START_RIGHT(XR),
        .SCREEN_W     (SCR_W),
        .GROUND_Y     (GND),
        .TICK_DIV     (TICK),
        .TARGET_W     (TGT),
        .TARGET_H     (TGT)
    ) dut (
        .clk60MHz     (clk60MHz),
        .rst          (rst),
        .in_throw_flag(in_throw_flag),
        .throw_flag   (throw_flag),
        .power        (power),
`ifdef THROW_WIND_EN
        .wind         (wind),
`endif
        .ypos_prebuff (ypos_prebuff),
        .target_xpos  (target_xpos),
        .target_ypos  (target_ypos),
        .xpos_prebuff (xpos_prebuff),
        .end_throw    (end_throw),
        .hit          (hit),
        .busy         (busy)
    );

    // 60 MHz-style free-running clock (period is arbitrary in simulation).
    initial clk60MHz = 1'b0;
    always #5 clk60MHz = ~clk60MHz;

    typedef struct {
        bit right;
        int pwr;
        int y;
        int tx;
        int ty;
        int exp_j;
        int exp_x;
        int exp_hits;
    } vec_t;

    vec_t vecs[8];

    int exp_x[$];
    int exp_end;
    bit exp_hit;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk60MHz);
        #1;
    endtask

    // Trajectory model: launch X plus one speed step per elapsed tick. Each
    // cycle it checks hit, then ground, then screen exit on tick cycles.
    task automatic predict(input bit right, input int spd, input int y, input int tx, input int ty);
        int x;
        x = right ? XL : XR;
        exp_x = {};
        exp_x.push_back(x);
        exp_end = 0;
        exp_hit = 0;
        for (int j = 1; j <= MAX_WAIT && exp_end == 0; j++) begin
            if (x >= tx && x < tx + TGT && y >= ty && y < ty + TGT) begin
                exp_end = j;
                exp_hit = 1;
            end else if (y > GND) begin
                exp_end = j;
            end else if (j % TICK == 0) begin
                if (right) begin
                    if (x + spd >= SCR_W) begin
                        x = SCR_W - 1;
                        exp_end = j;
                    end else begin
                        x = x + spd;
                    end
                end else begin
                    if (x < spd) begin
                        x = 0;
                        exp_end = j;
                    end else begin
                        x = x - spd;
                    end
                end
            end
            exp_x.push_back(x);
        end
    endtask

    task automatic launch(input bit left_req, input bit right_req, input int pwr, input int y,
                          input int tx, input int ty);
        power         = 5'(pwr);
        ypos_prebuff  = 12'(y);
        target_xpos   = 12'(tx);
        target_ypos   = 12'(ty);
        in_throw_flag = left_req;
        throw_flag    = right_req;
        step();
        in_throw_flag = 1'b0;
        throw_flag    = 1'b0;
    endtask

    task automatic releaseGround(input string name);
        ypos_prebuff = 12'(GND);
        step();
        checkOutput({name, "_end_fall"}, int'(end_throw), 0);
        checkOutput({name, "_busy_fall"}, int'(busy), 0);
    endtask

    // Runs one table throw and compares end cycle, final X and hit pulse.
    task automatic applyStimulus(input vec_t v, input int idx);
        int    j_end;
        int    x_end;
        int    hits;
        int    hit_on_end;
        string nm;
        nm = $sformatf("vec%0d", idx);
        launch(v.right, !v.right, v.pwr, v.y, v.tx, v.ty);
        checkOutput({nm, "_busy"}, int'(busy), 1);
        j_end = -1;
        x_end = -1;
        hits = 0;
        hit_on_end = 0;
        for (int j = 1; j <= MAX_WAIT && j_end < 0; j++) begin
            step();
            if (hit) hits++;
            if (end_throw) begin
                j_end = j;
                x_end = int'(xpos_prebuff);
                hit_on_end = int'(hit);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            if (hit) hits++;
        end
        checkOutput({nm, "_end_cycle"}, j_end, v.exp_j);
        checkOutput({nm, "_final_x"}, x_end, v.exp_x);
        checkOutput({nm, "_hits"}, hits, v.exp_hits);
        checkOutput({nm, "_hit_on_end"}, hit_on_end, v.exp_hits);
        checkOutput({nm, "_x_frozen"}, int'(xpos_prebuff), v.exp_x);
        checkOutput({nm, "_end_held"}, int'(end_throw), 1);
        releaseGround(nm);
    endtask

    // Random throw compared every cycle against the trajectory model.
    task automatic randomThrow(input int idx);
        bit    right;
        int    pwr;
        int    y;
        int    tx;
        int    ty;
        int    bad;
        int    first_bad;
        int    jj;
        string nm;
        nm = $sformatf("rand%0d", idx);
        right = 1'($urandom_range(0, 1));
        pwr = $urandom_range(2, 31);
        y = ($urandom_range(0, 9) == 0) ? $urandom_range(GND + 1, GND + 40) : $urandom_range(600, GND - 1);
        tx = $urandom_range(0, 1000);
        ty = ($urandom_range(0, 1) == 1) ? y - $urandom_range(0, TGT - 1) : 0;
        predict(right, pwr, y, tx, ty);
        launch(right, !right, pwr, y, tx, ty);
        bad = 0;
        first_bad = -1;
        for (int j = 1; j <= exp_end + 2; j++) begin
            step();
            jj = (j < exp_end) ? j : exp_end;
            if (int'(xpos_prebuff) != exp_x[jj] ||
                end_throw != (j >= exp_end) ||
                hit != (exp_hit && j == exp_end) ||
                busy != 1'b1) begin
                bad++;
                if (first_bad < 0) first_bad = j;
            end
        end
        if (bad != 0)
            $display("[TB] %s first divergent cycle %0d x=%0d model_x=%0d", nm, first_bad,
                     xpos_prebuff, exp_x[exp_end]);
        checkOutput({nm, "_trace_mismatches"}, bad, 0);
        releaseGround(nm);
    endtask

    initial begin
        vecs[0] = '{1'b1, 10, 700, 2000, 0,   372,  1023, 0};
        vecs[1] = '{1'b0, 0,  700, 880,  650, 1,    900,  1};
        vecs[2] = '{1'b0, 31, 700, 2000, 0,   120,  0,    0};
        vecs[3] = '{1'b1, 5,  769, 2000, 0,   1,    100,  0};
        vecs[4] = '{1'b1, 20, 700, 300,  690, 41,   300,  1};
        vecs[5] = '{1'b1, 10, 769, 90,   760, 1,    100,  1};
        vecs[6] = '{1'b0, 3,  700, 2000, 0,   1204, 0,    0};
        vecs[7] = '{1'b1, 31, 700, 2000, 0,   120,  1023, 0};

        rst = 1'b1;
        in_throw_flag = 1'b0;
        throw_flag = 1'b0;
        power = 5'd0;
`ifdef THROW_WIND_EN
        wind = 4'sd0;
`endif
        ypos_prebuff = 12'(GND);
        target_xpos = 12'd2000;
        target_ypos = 12'd0;
        #22;
        checkOutput("reset_x", int'(xpos_prebuff), XL);
        checkOutput("reset_end", int'(end_throw), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_hit", int'(hit), 0);
        rst = 1'b0;
        begin
            int moved;
            moved = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (xpos_prebuff != 12'(XL) || busy || end_throw || hit) moved++;
            end
            checkOutput("idle_hold", moved, 0);
        end

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        // Both requests together: the left player wins. Flags toggled in
        // flight and while terminating must be ignored.
        launch(1'b1, 1'b1, 10, 700, 2000, 0);
        checkOutput("both_x", int'(xpos_prebuff), XL);
        for (int i = 0; i < 8; i++) begin
            in_throw_flag = 1'(i % 2);
            throw_flag = 1'(~i % 2);
            step();
        end
        checkOutput("toggle_fly_x", int'(xpos_prebuff), 120);
        ypos_prebuff = 12'(GND + 1);
        step();
        checkOutput("toggle_end", int'(end_throw), 1);
        for (int i = 0; i < 4; i++) begin
            in_throw_flag = 1'(i % 2);
            throw_flag = 1'b1;
            step();
        end
        checkOutput("toggle_done_x", int'(xpos_prebuff), 120);
        checkOutput("toggle_done_busy", int'(busy), 1);
        in_throw_flag = 1'b0;
        throw_flag = 1'b0;
        releaseGround("toggle");
        checkOutput("idle_x_hold", int'(xpos_prebuff), 120);

        // Reset in the middle of a flight returns to reset values at once.
        launch(1'b0, 1'b1, 10, 700, 2000, 0);
        for (int i = 0; i < 6; i++) step();
        checkOutput("pre_rst_x", int'(xpos_prebuff), 890);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_x", int'(xpos_prebuff), XL);
        checkOutput("rst_mid_busy", int'(busy), 0);
        checkOutput("rst_mid_end", int'(end_throw), 0);
        checkOutput("rst_mid_hit", int'(hit), 0);
        step();
        rst = 1'b0;
        step();
        checkOutput("post_rst_busy", int'(busy), 0);
        checkOutput("post_rst_hit", int'(hit), 0);

`ifdef THROW_WIND_EN
        wind = -4'sd8;
        launch(1'b1, 1'b0, 5, 700, 2000, 0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("wind_low_x", int'(xpos_prebuff), XL + 1);
        ypos_prebuff = 12'(GND + 1);
        step();
        releaseGround("wind_low");
        wind = 4'sd7;
        launch(1'b1, 1'b0, 30, 700, 2000, 0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("wind_high_x", int'(xpos_prebuff), XL + 31);
        wind = -4'sd8;
        for (int i = 0; i < 4; i++) step();
        checkOutput("wind_change_x", int'(xpos_prebuff), XL + 62);
        ypos_prebuff = 12'(GND + 1);
        step();
        releaseGround("wind_high");
        wind = 4'sd0;
`endif

        for (int i = 0; i < 12; i++) randomThrow(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
